rst_seq: RTL and testbench

Multi-channel reset sequencer; successor to the single-output reset synchronizer.
- Synchronizes one asynchronous active-high reset into the local clock domain.
- Holds all reset outputs asserted for a minimum stretch period, then releases NUM_CHANNELS outputs in order with a fixed gap between releases.
- Supports a software-initiated reset through a four-phase req/ack handshake.
- Sits at top level and drives codec, FFT and bus-fabric resets in dependency order.

---
 rtl/rst_seq_if.sv | 28 ++
 rtl/rst_seq.sv | 198 +++++++++++++++++++
 tb/tb_rst_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_if.sv
// Handshake and reset-output bundle between rst_seq and the logic it controls.
// The master side issues software reset requests and watches the sequenced resets.
// The slave side is the sequencer itself.
interface rst_seq_if #(
  parameter int NUM_CHANNELS = 4
);
  logic                    sw_rst_req;
  logic                    sw_rst_ack;
  logic [NUM_CHANNELS-1:0] rst_chan_out;
  logic                    busy;
  logic                    seq_done;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack,
    input  rst_chan_out,
    input  busy,
    input  seq_done
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack,
    output rst_chan_out,
    output busy,
    output seq_done
  );
endinterface

// File: rtl/rst_seq.sv
// Multi-channel reset sequencer.
// - Synchronizes rst_async into the clk domain.
// - Holds every channel asserted for a stretch period.
// - Releases the channels in order, 0 first, with a fixed gap between them.
// - Accepts a software reset request through a four-phase req/ack handshake.
// Optional feature: define RST_SEQ_SW_REQ_SYNC_EN to pass sw_rst_req through a
// 2-flop synchronizer, so the request may come from another clock domain.
module rst_seq #(
  parameter string MODULE_NAME       = "RST_SEQ",
  parameter bit    ACTIVE_LOW_N_HIGH = 1'b1,
  parameter int    NUM_STAGES        = 2,
  parameter int    NUM_CHANNELS      = 4,
  parameter int    STRETCH_CYCLES    = 16,
  parameter int    GAP_CYCLES        = 8,
  parameter int    CNTR_W            = 8
) (
  input  logic        clk,
  input  logic        rst_async,
  rst_seq_if.slave    bus
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam bit ASSERT_BIT  = ~ACTIVE_LOW_N_HIGH;
  localparam bit RELEASE_BIT = ACTIVE_LOW_N_HIGH;
  localparam logic [NUM_CHANNELS-1:0] CH_ASSERTED = {NUM_CHANNELS{ASSERT_BIT}};
  localparam logic [NUM_CHANNELS-1:0] CH_RELEASED = {NUM_CHANNELS{RELEASE_BIT}};
  localparam logic [CNTR_W-1:0] STRETCH_C = CNTR_W'(STRETCH_CYCLES);
  localparam logic [CNTR_W-1:0] GAP_LAST  = CNTR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHANNELS - 1);

  // Reject configurations the sequencer cannot implement correctly.
  if (NUM_STAGES < 2) begin : g_bad_stages
    $error("%s: NUM_STAGES must be at least 2", MODULE_NAME);
  end
  if (NUM_CHANNELS < 1) begin : g_bad_channels
    $error("%s: NUM_CHANNELS must be at least 1", MODULE_NAME);
  end
  if ((2 ** CNTR_W) <= ((STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES)) begin : g_bad_cntr
    $error("%s: CNTR_W too narrow for STRETCH_CYCLES/GAP_CYCLES", MODULE_NAME);
  end

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNTR_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] chan_q, chan_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    pending_q, pending_d;
  logic [NUM_STAGES-1:0]   sync_q;
  logic                    rst_int;
  logic                    rst_int_q;
  logic                    req_s;

  // Reset synchronizer: asserts immediately, shifts the inactive value in on deassertion.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b0};
    end
  end

  assign rst_int = sync_q[NUM_STAGES-1];

`ifdef RST_SEQ_SW_REQ_SYNC_EN
  logic [1:0] req_sync_q;

  // Two-flop synchronizer for a software request arriving from another clock domain.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      req_sync_q <= 2'b00;
    end else begin
      req_sync_q <= {req_sync_q[0], bus.sw_rst_req};
    end
  end

  assign req_s = req_sync_q[1];
`else
  assign req_s = bus.sw_rst_req;
`endif

  // State and output registers. The FSM sees a registered copy of rst_int, so the
  // stretch count starts one cycle after the synchronizer output goes inactive.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state_q   <= ST_ASSERT;
      cnt_q     <= '0;
      idx_q     <= '0;
      chan_q    <= CH_ASSERTED;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      pending_q <= 1'b0;
      rst_int_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      chan_q    <= chan_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      pending_q <= pending_d;
      rst_int_q <= rst_int;
    end
  end

  // Next-state logic: stretch, staggered release, then wait for a software request.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    chan_d    = chan_q;
    done_d    = done_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    pending_d = pending_q;

    if (!req_s) begin
      ack_d = 1'b0;
    end

    case (state_q)
      ST_ASSERT: begin
        chan_d = CH_ASSERTED;
        done_d = 1'b0;
        busy_d = 1'b1;
        if (!rst_int_q) begin
          if (cnt_q == STRETCH_C) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            if (GAP_CYCLES == 0) begin
              chan_d = CH_RELEASED;
              idx_d  = LAST_IDX;
            end else begin
              chan_d[0] = RELEASE_BIT;
              idx_d     = '0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          if (pending_q) begin
            ack_d     = 1'b1;
            pending_d = 1'b0;
          end
        end else if (cnt_q == GAP_LAST) begin
          idx_d = idx_q + 1'b1;
          cnt_d = '0;
          for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (k == int'(idx_d)) begin
              chan_d[k] = RELEASE_BIT;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (req_s && !ack_q) begin
          state_d   = ST_ASSERT;
          cnt_d     = '0;
          idx_d     = '0;
          chan_d    = CH_ASSERTED;
          done_d    = 1'b0;
          busy_d    = 1'b1;
          pending_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase
  end

  assign bus.rst_chan_out = chan_q;
  assign bus.seq_done     = done_q;
  assign bus.busy         = busy_q;
  assign bus.sw_rst_ack   = ack_q;

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq.
// Main instance uses default parameters; a second instance covers the
// active-high, zero-stretch, zero-gap configuration.
// The reference model predicts outputs from a timeline: each sequence has an
// origin edge t0 and a base offset B, channel k is released from edge t0+B+k*GAP,
// and seq_done rises one edge after the last release.
module tb_rst_seq;

  localparam int N       = 4;
  localparam int STAGES  = 2;
  localparam int STRETCH = 16;
  localparam int GAP     = 8;
`ifdef RST_SEQ_SW_REQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_async = 1'b1;

  rst_seq_if #(.NUM_CHANNELS(N)) bus ();
  rst_seq_if #(.NUM_CHANNELS(3)) bus5 ();

  rst_seq dut (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus)
  );

  rst_seq #(
    .ACTIVE_LOW_N_HIGH (1'b0),
    .NUM_CHANNELS      (3),
    .STRETCH_CYCLES    (0),
    .GAP_CYCLES        (0)
  ) dut5 (
    .clk       (clk),
    .rst_async (rst_async),
    .bus       (bus5)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;

  int     g;
  bit     need_origin;
  int     t0;
  int     base;
  bit     pending_m;
  bit     ack_m;
  bit     done_m;
  bit     h1, h2;
  logic [N-1:0] chan_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s at edge %0d: observed %0h expected %0h", tag, g, obs, exp);
    end
  endtask

  task automatic reset_model();
    need_origin = 1'b1;
    pending_m   = 1'b0;
    ack_m       = 1'b0;
    done_m      = 1'b0;
    h1          = 1'b0;
    h2          = 1'b0;
    chan_m      = '0;
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit req_eff;
    bit done_prev;
    g++;
    if (rst_async) begin
      reset_model();
      return;
    end
    if (need_origin) begin
      t0          = g;
      base        = STAGES + STRETCH + 1;
      need_origin = 1'b0;
    end
    req_eff = (SYNC_LAT != 0) ? h2 : bus.sw_rst_req;
    h2 = h1;
    h1 = bus.sw_rst_req;
    done_prev = done_m;
    if (done_prev && req_eff && !ack_m) begin
      t0        = g;
      base      = STRETCH + 1;
      pending_m = 1'b1;
    end
    done_m = (g >= t0 + base + (N - 1) * GAP + 1);
    if (!done_prev && done_m && pending_m) begin
      ack_m     = 1'b1;
      pending_m = 1'b0;
    end else if (!req_eff) begin
      ack_m = 1'b0;
    end
    for (int k = 0; k < N; k++) begin
      chan_m[k] = (g >= t0 + base + k * GAP);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, "_chan"}, 32'(bus.rst_chan_out), 32'(chan_m));
    check({tag, "_done"}, 32'(bus.seq_done), 32'(done_m));
    check({tag, "_busy"}, 32'(bus.busy), 32'(!done_m));
    check({tag, "_ack"}, 32'(bus.sw_rst_ack), 32'(ack_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_output("step");
  endtask

  // Assert rst_async between edges, confirm outputs assert without a clock edge.
  task automatic pulse_reset(input int hold);
    #2 rst_async = 1'b1;
    #1 reset_model();
    check_output("async");
    check("async_dut5_chan", 32'(bus5.rst_chan_out), 32'h7);
    repeat (hold) step();
    rst_async = 1'b0;
  endtask

  task automatic apply_stimulus(input int kind);
    case (kind)
      0: begin
        bus.sw_rst_req = 1'b1;
        repeat ($urandom_range(1, 60)) step();
        bus.sw_rst_req = 1'b0;
        step();
      end
      1: begin
        repeat ($urandom_range(1, 30)) step();
      end
      2: begin
        repeat ($urandom_range(0, 45)) step();
        pulse_reset($urandom_range(1, 3));
      end
      default: begin
        bus.sw_rst_req = 1'b1;
        repeat ($urandom_range(1, 10)) step();
        bus.sw_rst_req = 1'b0;
        repeat ($urandom_range(1, 3)) step();
        bus.sw_rst_req = 1'b1;
        repeat ($urandom_range(40, 60)) step();
        bus.sw_rst_req = 1'b0;
        step();
      end
    endcase
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    g              = 0;
    t0             = 0;
    base           = 0;
    bus.sw_rst_req = 1'b0;
    bus5.sw_rst_req = 1'b0;
    reset_model();

    // Power-on reset held for 10 cycles, then released.
    repeat (10) begin
      step();
      check("rst_dut5_chan", 32'(bus5.rst_chan_out), 32'h7);
      check("rst_dut5_done", 32'(bus5.seq_done), 32'h0);
    end
    rst_async = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (g - t0 <= 5) begin
        check("dut5_chan", 32'(bus5.rst_chan_out), (g - t0 >= 3) ? 32'h0 : 32'h7);
        check("dut5_done", 32'(bus5.seq_done), (g - t0 >= 4) ? 32'h1 : 32'h0);
      end
    end
    check("hw_final_chan", 32'(bus.rst_chan_out), 32'hF);
    check("hw_final_done", 32'(bus.seq_done), 32'h1);

    // Software reset request, released after the sequence completes.
    bus.sw_rst_req = 1'b1;
    repeat (50) step();
    check("sw_ack_high", 32'(bus.sw_rst_ack), 32'h1);
    bus.sw_rst_req = 1'b0;
    repeat (3) step();

    // Request held far beyond the acknowledge: no second sequence may start.
    bus.sw_rst_req = 1'b1;
    repeat (100) step();
    check("held_req_done", 32'(bus.seq_done), 32'h1);
    bus.sw_rst_req = 1'b0;
    repeat (4) step();
    bus.sw_rst_req = 1'b1;
    repeat (55) step();
    bus.sw_rst_req = 1'b0;
    repeat (4) step();

    // Reset pulse during a hardware sequence, after channels 0 and 1 release.
    pulse_reset(4);
    repeat (30) step();
    pulse_reset(3);
    repeat (50) step();

    // Randomized mix of requests, idles and reset pulses.
    repeat (25) apply_stimulus($urandom_range(0, 3));
    bus.sw_rst_req = 1'b0;
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
